// File: rtl/instr_queue.sv
// instr_queue: circular {pc, instr} FIFO between fetcher and decoder, flushed by the ROB.
// Define IQ_BYPASS_EN to forward a push straight to the decoder outputs when the queue is empty.
module instr_queue #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy_in,
  input  logic               clr_from_rob,
  input  logic               valid_from_if,
  input  logic [PC_W-1:0]    pc_from_if,
  input  logic [INSTR_W-1:0] instr_from_if,
  output logic               full_to_if,
  input  logic               pop_from_issue,
  output logic               is_empty_to_dc,
  output logic [PC_W-1:0]    pc_to_dc,
  output logic [INSTR_W-1:0] instr_to_dc,
  output logic [ADDR_W:0]    count_out
);
  logic [PC_W+INSTR_W-1:0] mem_q [DEPTH];
  logic [PC_W+INSTR_W-1:0] head_ent;
  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_W:0] count_q, count_d;
  logic empty, full, clr_eff, pop_eff, push_eff, wr_en;
`ifdef IQ_BYPASS_EN
  logic byp, byp_pop;
`endif
  always_comb begin
    empty    = count_q == '0;
    full     = count_q == (ADDR_W+1)'(DEPTH);
    clr_eff  = rdy_in & clr_from_rob;
    pop_eff  = rdy_in & pop_from_issue & ~empty;
    push_eff = rdy_in & valid_from_if & (~full | pop_eff);
`ifdef IQ_BYPASS_EN
    // An entry forwarded and consumed in the same cycle never touches the array.
    byp      = empty & valid_from_if & ~clr_eff;
    byp_pop  = byp & rdy_in & pop_from_issue;
    push_eff = push_eff & ~byp_pop;
`endif
    wr_en    = push_eff & ~clr_eff;
    head_d   = clr_eff ? '0 : head_q + ADDR_W'(pop_eff);
    tail_d   = clr_eff ? '0 : tail_q + ADDR_W'(push_eff);
    count_d  = clr_eff ? '0 : count_q + (ADDR_W+1)'(push_eff) - (ADDR_W+1)'(pop_eff);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail_q] <= {pc_from_if, instr_from_if};
  end
  always_comb begin
    head_ent = mem_q[head_q];
    full_to_if  = full;
    count_out   = count_q;
`ifdef IQ_BYPASS_EN
    is_empty_to_dc = empty & ~byp;
    pc_to_dc    = byp ? pc_from_if : empty ? '0 : head_ent[PC_W+INSTR_W-1:INSTR_W];
    instr_to_dc = byp ? instr_from_if : empty ? '0 : head_ent[INSTR_W-1:0];
`else
    is_empty_to_dc = empty;
    pc_to_dc    = empty ? '0 : head_ent[PC_W+INSTR_W-1:INSTR_W];
    instr_to_dc = empty ? '0 : head_ent[INSTR_W-1:0];
`endif
  end
endmodule
